// File: rtl/sram_wb_bridge_if.sv
// ----------------------------------------------------------------------------
// sram_wb_bridge_if
// Groups the Wishbone slave-side signals and the single-port SRAM signals used
// by sram_wb_bridge. Clock and reset are not carried here; they stay plain
// ports on the bridge.
//
// Handshake: a request is wb_cyc_i & wb_stb_i. The master holds the request
// stable until it sees wb_ack_o high for one cycle. Dropping wb_cyc_i before
// the ack abandons the transaction and no ack is returned for it.
//
// Signals:
//   wb_cyc_i, wb_stb_i   request qualifiers (master -> bridge)
//   wb_we_i              1 = write, 0 = read
//   wb_sel_i[3:0]        byte lanes, bit n covers data[8n+7:8n]
//   wb_adr_i[8:0]        word address
//   wb_dat_i[31:0]       write data
//   wb_dat_o[31:0]       read data (bridge -> master)
//   wb_ack_o             one-cycle acknowledge (bridge -> master)
//   sram_en, sram_wen    SRAM access / full-word write enable (bridge -> SRAM)
//   sram_addr[8:0]       SRAM word address
//   sram_wdata[31:0]     SRAM write data
//   sram_rdata[31:0]     SRAM read data, valid the cycle after a read access
// ----------------------------------------------------------------------------
interface sram_wb_bridge_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [8:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        sram_en;
  logic [8:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_wen;
  logic [31:0] sram_rdata;

  // Bridge side.
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o,
    output sram_en, sram_addr, sram_wdata, sram_wen,
    input  sram_rdata
  );

  // Bus master plus SRAM side.
  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o,
    input  sram_en, sram_addr, sram_wdata, sram_wen,
    output sram_rdata
  );
endinterface

// File: rtl/sram_wb_bridge.sv
// ----------------------------------------------------------------------------
// sram_wb_bridge
// Wishbone slave in front of a 512 x 32 single-port SRAM that only supports
// full-word writes. Byte-lane writes are done as read-modify-write.
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   bus          sram_wb_bridge_if.slave (Wishbone + SRAM signals)
//   o_dbg_state  current FSM state, for debug/observation (IDLE = 0)
//
// Latency from the cycle a request is first sampled (C0):
//   full write  : SRAM write in C1, ack in C2
//   read        : SRAM read in C1, data captured end of C2, ack in C3
//   partial wr  : SRAM read in C1, merged write in C3, ack in C4
//   sel = 0 wr  : no SRAM access, ack in C2
// After the ack cycle the FSM spends one cycle in IDLE before accepting again.
// All bus and SRAM outputs are registered.
// ----------------------------------------------------------------------------
module sram_wb_bridge (
  input  logic                 clk,
  input  logic                 reset,
  sram_wb_bridge_if.slave      bus,
  output logic [2:0]           o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,  // SRAM access cycle (read or full write)
    RD_WAIT = 3'd2,  // SRAM read data valid this cycle
    MERGE   = 3'd3,  // merged partial write on the SRAM
    WR_DONE = 3'd4,  // sel=0 write: nothing to do on the SRAM
    ACK     = 3'd5   // wb_ack_o high; requests ignored
  } state_t;

  state_t      r_state, w_nxt_state;
  logic        r_we, w_nxt_we;
  logic [3:0]  r_sel, w_nxt_sel;
  logic [31:0] r_dat, w_nxt_dat;
  logic        r_ack, w_nxt_ack;
  logic [31:0] r_dat_o, w_nxt_dat_o;
  logic        r_sram_en, w_nxt_sram_en;
  logic        r_sram_wen, w_nxt_sram_wen;
  logic [8:0]  r_sram_addr, w_nxt_sram_addr;
  logic [31:0] r_sram_wdata, w_nxt_sram_wdata;

  logic        w_req;
  logic [31:0] w_merged;

  assign w_req = bus.wb_cyc_i & bus.wb_stb_i;

  // Selected lanes come from the latched write data, the rest from the SRAM.
  always_comb begin
    w_merged = 32'h0;
    for (int n = 0; n < 4; n++) begin
      w_merged[8*n +: 8] = r_sel[n] ? r_dat[8*n +: 8] : bus.sram_rdata[8*n +: 8];
    end
  end

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_we         = r_we;
    w_nxt_sel        = r_sel;
    w_nxt_dat        = r_dat;
    w_nxt_ack        = 1'b0;
    w_nxt_dat_o      = r_dat_o;
    w_nxt_sram_en    = 1'b0;
    w_nxt_sram_wen   = 1'b0;
    w_nxt_sram_addr  = r_sram_addr;
    w_nxt_sram_wdata = r_sram_wdata;

    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_nxt_we  = bus.wb_we_i;
          w_nxt_sel = bus.wb_sel_i;
          w_nxt_dat = bus.wb_dat_i;
          if (bus.wb_we_i && (bus.wb_sel_i == 4'h0)) begin
            w_nxt_state = WR_DONE;
          end else begin
            // Reads and partial writes both start with an SRAM read.
            w_nxt_state      = ISSUE;
            w_nxt_sram_en    = 1'b1;
            w_nxt_sram_addr  = bus.wb_adr_i;
            w_nxt_sram_wen   = bus.wb_we_i && (bus.wb_sel_i == 4'hF);
            w_nxt_sram_wdata = bus.wb_dat_i;
          end
        end
      end
      ISSUE: begin
        // A full write was already performed on the edge ending C1, so an
        // abort here only suppresses the ack.
        if (!bus.wb_cyc_i) begin
          w_nxt_state = IDLE;
        end else if (r_we && (r_sel == 4'hF)) begin
          w_nxt_state = ACK;
          w_nxt_ack   = 1'b1;
        end else begin
          w_nxt_state = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (!bus.wb_cyc_i) begin
          w_nxt_state = IDLE;            // merge abandoned, no write issued
        end else if (!r_we) begin
          w_nxt_state = ACK;
          w_nxt_ack   = 1'b1;
          w_nxt_dat_o = bus.sram_rdata;  // full word regardless of sel
        end else begin
          w_nxt_state      = MERGE;
          w_nxt_sram_en    = 1'b1;
          w_nxt_sram_wen   = 1'b1;
          w_nxt_sram_wdata = w_merged;
        end
      end
      MERGE, WR_DONE: begin
        if (!bus.wb_cyc_i) begin
          w_nxt_state = IDLE;
        end else begin
          w_nxt_state = ACK;
          w_nxt_ack   = 1'b1;
        end
      end
      ACK: begin
        w_nxt_state = IDLE;
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_sel        <= 4'h0;
      r_dat        <= 32'h0;
      r_ack        <= 1'b0;
      r_dat_o      <= 32'h0;
      r_sram_en    <= 1'b0;
      r_sram_wen   <= 1'b0;
      r_sram_addr  <= 9'h0;
      r_sram_wdata <= 32'h0;
    end else begin
      r_state      <= w_nxt_state;
      r_we         <= w_nxt_we;
      r_sel        <= w_nxt_sel;
      r_dat        <= w_nxt_dat;
      r_ack        <= w_nxt_ack;
      r_dat_o      <= w_nxt_dat_o;
      r_sram_en    <= w_nxt_sram_en;
      r_sram_wen   <= w_nxt_sram_wen;
      r_sram_addr  <= w_nxt_sram_addr;
      r_sram_wdata <= w_nxt_sram_wdata;
    end
  end

  assign bus.wb_ack_o   = r_ack;
  assign bus.wb_dat_o   = r_dat_o;
  assign bus.sram_en    = r_sram_en;
  assign bus.sram_wen   = r_sram_wen;
  assign bus.sram_addr  = r_sram_addr;
  assign bus.sram_wdata = r_sram_wdata;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_sram_wb_bridge.sv
// ----------------------------------------------------------------------------
// tb_sram_wb_bridge
// Directed bench for sram_wb_bridge with a behavioural 512 x 32 SRAM model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at
// the same point, so "cycle Ck" below is the cycle after the k-th edge
// following the request cycle C0.
// ----------------------------------------------------------------------------
module tb_sram_wb_bridge;

  logic        clk;
  logic        reset;
  logic [2:0]  dbg_state;
  sram_wb_bridge_if bus();

  logic [31:0] mem [512];
  int          n_sram_writes;
  int          n_checks;
  int          n_errors;

  sram_wb_bridge dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: synchronous, read data valid the cycle after the access.
  initial n_sram_writes = 0;
  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_wen) begin
        mem[bus.sram_addr] <= bus.sram_wdata;
        n_sram_writes      <= n_sram_writes + 1;
      end else begin
        bus.sram_rdata <= mem[bus.sram_addr];
      end
    end
  end

  // sram_wen must never be high without sram_en.
  always @(negedge clk) begin
    if (!reset) begin
      n_checks++;
      if (bus.sram_wen && !bus.sram_en) begin
        n_errors++;
        $display("FAIL wen_without_en: got wen=%b en=%b required wen=0", bus.sram_wen, bus.sram_en);
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [3:0] sel,
                           input logic [8:0] adr, input logic [31:0] dat);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_sel_i = sel;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
  endtask

  task automatic drive_idle();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = 4'h0;
    bus.wb_adr_i = 9'h0;
    bus.wb_dat_i = 32'h0;
  endtask

  // Reset values, and a request held during reset accepted only afterwards.
  task automatic test_reset();
    reset = 1'b1;
    drive_req(1'b1, 4'h0, 9'h055, 32'hFFFF_FFFF);
    next_cycle();
    next_cycle();
    n_checks++;
    if ({bus.wb_ack_o, bus.sram_en, bus.sram_wen} !== 3'b000) begin
      n_errors++;
      $display("FAIL rst_ctrl: got ack/en/wen=%b required 000", {bus.wb_ack_o, bus.sram_en, bus.sram_wen});
    end
    n_checks++;
    if ({bus.wb_dat_o, bus.sram_wdata, bus.sram_addr} !== 73'h0) begin
      n_errors++;
      $display("FAIL rst_data: got dat_o=%h wdata=%h addr=%h required all 0", bus.wb_dat_o, bus.sram_wdata, bus.sram_addr);
    end
    n_checks++;
    if (dbg_state !== 3'd0) begin
      n_errors++;
      $display("FAIL rst_state: got %0d required 0 (IDLE)", dbg_state);
    end
    reset = 1'b0;                          // this cycle is C0
    next_cycle();                          // C1
    n_checks++;
    if ({bus.wb_ack_o, bus.sram_en} !== 2'b00) begin
      n_errors++;
      $display("FAIL rst_req_c1: got ack/en=%b required 00", {bus.wb_ack_o, bus.sram_en});
    end
    next_cycle();                          // C2
    n_checks++;
    if (bus.wb_ack_o !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_req_ack_c2: got %b required 1", bus.wb_ack_o);
    end
    drive_idle();
    next_cycle();                          // C3
    n_checks++;
    if (bus.wb_ack_o !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_req_ack_c3: got %b required 0", bus.wb_ack_o);
    end
  endtask

  task automatic test_full_write();
    drive_req(1'b1, 4'hF, 9'h1A5, 32'hDEAD_BEEF);
    next_cycle();                          // C1
    n_checks++;
    if ({bus.sram_en, bus.sram_wen, bus.sram_addr, bus.sram_wdata, bus.wb_ack_o} !== {1'b1, 1'b1, 9'h1A5, 32'hDEAD_BEEF, 1'b0}) begin
      n_errors++;
      $display("FAIL fw_c1: got en=%b wen=%b addr=%h wdata=%h ack=%b required 1 1 1a5 deadbeef 0",
               bus.sram_en, bus.sram_wen, bus.sram_addr, bus.sram_wdata, bus.wb_ack_o);
    end
    next_cycle();                          // C2
    n_checks++;
    if ({bus.wb_ack_o, bus.sram_en} !== 2'b10) begin
      n_errors++;
      $display("FAIL fw_c2: got ack/en=%b required 10", {bus.wb_ack_o, bus.sram_en});
    end
    drive_idle();
    next_cycle();                          // C3
    n_checks++;
    if (bus.wb_ack_o !== 1'b0) begin
      n_errors++;
      $display("FAIL fw_c3_ack: got %b required 0", bus.wb_ack_o);
    end
    n_checks++;
    if (mem[9'h1A5] !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL fw_mem: got %h required deadbeef", mem[9'h1A5]);
    end
  endtask

  task automatic test_read();
    drive_req(1'b0, 4'h3, 9'h1A5, 32'h0);
    next_cycle();                          // C1
    n_checks++;
    if ({bus.sram_en, bus.sram_wen, bus.sram_addr, bus.wb_ack_o} !== {1'b1, 1'b0, 9'h1A5, 1'b0}) begin
      n_errors++;
      $display("FAIL rd_c1: got en=%b wen=%b addr=%h ack=%b required 1 0 1a5 0",
               bus.sram_en, bus.sram_wen, bus.sram_addr, bus.wb_ack_o);
    end
    next_cycle();                          // C2
    n_checks++;
    if ({bus.wb_ack_o, bus.sram_en} !== 2'b00) begin
      n_errors++;
      $display("FAIL rd_c2: got ack/en=%b required 00", {bus.wb_ack_o, bus.sram_en});
    end
    next_cycle();                          // C3
    n_checks++;
    if ({bus.wb_ack_o, bus.wb_dat_o} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_errors++;
      $display("FAIL rd_c3: got ack=%b dat=%h required 1 deadbeef", bus.wb_ack_o, bus.wb_dat_o);
    end
    drive_idle();
    next_cycle();                          // C4
    n_checks++;
    if ({bus.wb_ack_o, bus.wb_dat_o} !== {1'b0, 32'hDEAD_BEEF}) begin
      n_errors++;
      $display("FAIL rd_c4: got ack=%b dat=%h required 0 deadbeef", bus.wb_ack_o, bus.wb_dat_o);
    end
  endtask

  task automatic test_partial_write();
    // Preload the location with a full write.
    drive_req(1'b1, 4'hF, 9'h0C2, 32'h1122_3344);
    next_cycle();
    next_cycle();                          // ack cycle
    n_checks++;
    if (bus.wb_ack_o !== 1'b1) begin
      n_errors++;
      $display("FAIL pw_preload_ack: got %b required 1", bus.wb_ack_o);
    end
    drive_idle();
    next_cycle();
    // Partial write, lanes 0 and 2.
    drive_req(1'b1, 4'b0101, 9'h0C2, 32'hAABB_CCDD);
    next_cycle();                          // C1
    n_checks++;
    if ({bus.sram_en, bus.sram_wen} !== 2'b10) begin
      n_errors++;
      $display("FAIL pw_c1: got en/wen=%b required 10", {bus.sram_en, bus.sram_wen});
    end
    next_cycle();                          // C2
    n_checks++;
    if ({bus.sram_en, bus.wb_ack_o} !== 2'b00) begin
      n_errors++;
      $display("FAIL pw_c2: got en/ack=%b required 00", {bus.sram_en, bus.wb_ack_o});
    end
    next_cycle();                          // C3
    n_checks++;
    if ({bus.sram_en, bus.sram_wen, bus.sram_addr, bus.sram_wdata, bus.wb_ack_o} !== {1'b1, 1'b1, 9'h0C2, 32'h11BB_33DD, 1'b0}) begin
      n_errors++;
      $display("FAIL pw_c3: got en=%b wen=%b addr=%h wdata=%h ack=%b required 1 1 0c2 11bb33dd 0",
               bus.sram_en, bus.sram_wen, bus.sram_addr, bus.sram_wdata, bus.wb_ack_o);
    end
    next_cycle();                          // C4
    n_checks++;
    if ({bus.wb_ack_o, bus.sram_en} !== 2'b10) begin
      n_errors++;
      $display("FAIL pw_c4: got ack/en=%b required 10", {bus.wb_ack_o, bus.sram_en});
    end
    drive_idle();
    next_cycle();
    n_checks++;
    if (mem[9'h0C2] !== 32'h11BB_33DD) begin
      n_errors++;
      $display("FAIL pw_mem: got %h required 11bb33dd", mem[9'h0C2]);
    end
    n_checks++;
    if (bus.wb_dat_o !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL pw_dat_o_hold: got %h required deadbeef", bus.wb_dat_o);
    end
  endtask

  task automatic test_sel_zero();
    int w0;
    w0 = n_sram_writes;
    drive_req(1'b1, 4'h0, 9'h0C2, 32'hFFFF_FFFF);
    next_cycle();                          // C1
    n_checks++;
    if ({bus.sram_en, bus.wb_ack_o} !== 2'b00) begin
      n_errors++;
      $display("FAIL s0_c1: got en/ack=%b required 00", {bus.sram_en, bus.wb_ack_o});
    end
    next_cycle();                          // C2
    n_checks++;
    if ({bus.sram_en, bus.wb_ack_o} !== 2'b01) begin
      n_errors++;
      $display("FAIL s0_c2: got en/ack=%b required 01", {bus.sram_en, bus.wb_ack_o});
    end
    drive_idle();
    next_cycle();
    n_checks++;
    if ((mem[9'h0C2] !== 32'h11BB_33DD) || (n_sram_writes != w0)) begin
      n_errors++;
      $display("FAIL s0_mem: got mem=%h writes=%0d required 11bb33dd %0d", mem[9'h0C2], n_sram_writes, w0);
    end
  endtask

  task automatic test_reset_abort();
    int w0;
    w0 = n_sram_writes;
    drive_req(1'b1, 4'b0011, 9'h0C2, 32'h0);
    next_cycle();                          // C1
    n_checks++;
    if ({bus.sram_en, bus.sram_wen} !== 2'b10) begin
      n_errors++;
      $display("FAIL ra_c1: got en/wen=%b required 10", {bus.sram_en, bus.sram_wen});
    end
    next_cycle();                          // C2
    reset = 1'b1;
    next_cycle();                          // C3
    n_checks++;
    if ({bus.sram_en, bus.sram_wen, bus.wb_ack_o, bus.sram_addr, bus.sram_wdata, bus.wb_dat_o} !== 76'h0) begin
      n_errors++;
      $display("FAIL ra_c3: got en=%b wen=%b ack=%b addr=%h wdata=%h dat_o=%h required all 0",
               bus.sram_en, bus.sram_wen, bus.wb_ack_o, bus.sram_addr, bus.sram_wdata, bus.wb_dat_o);
    end
    reset = 1'b0;
    drive_idle();
    next_cycle();                          // C4
    n_checks++;
    if ((bus.wb_ack_o !== 1'b0) || (mem[9'h0C2] !== 32'h11BB_33DD) || (n_sram_writes != w0)) begin
      n_errors++;
      $display("FAIL ra_c4: got ack=%b mem=%h writes=%0d required 0 11bb33dd %0d",
               bus.wb_ack_o, mem[9'h0C2], n_sram_writes, w0);
    end
  endtask

  task automatic test_cyc_drop();
    drive_req(1'b0, 4'hF, 9'h1A5, 32'h0);
    next_cycle();                          // C1
    n_checks++;
    if (bus.sram_en !== 1'b1) begin
      n_errors++;
      $display("FAIL cd_c1: got en=%b required 1", bus.sram_en);
    end
    next_cycle();                          // C2: drop the cycle
    drive_idle();
    for (int k = 3; k <= 4; k++) begin
      next_cycle();
      n_checks++;
      if ((bus.wb_ack_o !== 1'b0) || (dbg_state !== 3'd0)) begin
        n_errors++;
        $display("FAIL cd_c%0d: got ack=%b state=%0d required 0 0", k, bus.wb_ack_o, dbg_state);
      end
    end
    // Fresh read from IDLE with normal latency.
    drive_req(1'b0, 4'hF, 9'h1A5, 32'h0);
    next_cycle();
    n_checks++;
    if ({bus.sram_en, bus.sram_wen} !== 2'b10) begin
      n_errors++;
      $display("FAIL cd_re_c1: got en/wen=%b required 10", {bus.sram_en, bus.sram_wen});
    end
    next_cycle();
    next_cycle();
    n_checks++;
    if ({bus.wb_ack_o, bus.wb_dat_o} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_errors++;
      $display("FAIL cd_re_c3: got ack=%b dat=%h required 1 deadbeef", bus.wb_ack_o, bus.wb_dat_o);
    end
    drive_idle();
    next_cycle();
  endtask

  // Requests held continuously: one transaction per latency+1 cycles.
  task automatic test_back_to_back();
    logic [7:0] exp_ack;
    logic [7:0] exp_en;
    // Full writes, latency 2: bit k is cycle Ck.
    exp_ack = 8'b0010_0100;
    exp_en  = 8'b0001_0010;
    drive_req(1'b1, 4'hF, 9'h010, 32'h0102_0304);
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      n_checks++;
      if ({bus.wb_ack_o, bus.sram_en} !== {exp_ack[k], exp_en[k]}) begin
        n_errors++;
        $display("FAIL b2b_wr_c%0d: got ack/en=%b%b required %b%b", k, bus.wb_ack_o, bus.sram_en, exp_ack[k], exp_en[k]);
      end
    end
    drive_idle();
    next_cycle();
    // Reads, latency 3.
    exp_ack = 8'b1000_1000;
    exp_en  = 8'b0010_0010;
    drive_req(1'b0, 4'hF, 9'h010, 32'h0);
    for (int k = 1; k <= 7; k++) begin
      next_cycle();
      n_checks++;
      if ({bus.wb_ack_o, bus.sram_en} !== {exp_ack[k], exp_en[k]}) begin
        n_errors++;
        $display("FAIL b2b_rd_c%0d: got ack/en=%b%b required %b%b", k, bus.wb_ack_o, bus.sram_en, exp_ack[k], exp_en[k]);
      end
      if (exp_ack[k]) begin
        n_checks++;
        if (bus.wb_dat_o !== 32'h0102_0304) begin
          n_errors++;
          $display("FAIL b2b_rd_dat_c%0d: got %h required 01020304", k, bus.wb_dat_o);
        end
      end
    end
    drive_idle();
    next_cycle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    drive_idle();
    test_reset();
    test_full_write();
    test_read();
    test_partial_write();
    test_sel_zero();
    test_reset_abort();
    test_cyc_drop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
